// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative 32-bit multiply/divide unit owning the HI/LO pair.
// Every operation takes exactly 33 clocks from accept to HI/LO update.
//
//   state | meaning
//   IDLE  | waiting; accepts start or direct HI/LO writes
//   CALC  | 32 shift-add / shift-subtract iterations on unsigned magnitudes
//   FIX   | sign correction and corner cases, HI/LO written
module muldiv_hilo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] mag_a, mag_b;
  logic        sign_a, sign_b;
  logic [63:0] acc;
  logic [4:0]  cnt;

  logic        neg_a_in, neg_b_in;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [31:0] div_rem;
  logic        div_qbit;
  logic        res_neg;
  logic [63:0] prod;
  logic [31:0] fix_hi, fix_lo;

  assign busy     = (state != IDLE);
  // Only signed ops take magnitudes; unsigned ops keep their raw values.
  assign neg_a_in = ~op[0] & rs_val[31];
  assign neg_b_in = ~op[0] & rt_val[31];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step: multiply adds into the upper half then shifts right;
  // divide brings in the next dividend bit (MSB first) and tries a subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (mag_b[cnt] ? {1'b0, mag_a} : 33'd0);
    div_shift = {acc[63:32], mag_a[5'd31 - cnt]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_qbit  = ~div_diff[32];
    div_rem   = div_qbit ? div_diff[31:0] : div_shift[31:0];
  end

  // Final HI/LO values including sign fix-up and divide-by-zero result.
  // The 0x80000000 / -1 case falls out naturally: quotient 2^31 negated wraps.
  always_comb begin
    res_neg = sign_a ^ sign_b;
    prod    = res_neg ? -acc : acc;
    fix_hi  = prod[63:32];
    fix_lo  = prod[31:0];
    if (op_q[1]) begin
      if (mag_b == 32'd0) begin
        fix_lo = 32'hFFFF_FFFF;
        fix_hi = sign_a ? -mag_a : mag_a;
      end else begin
        fix_lo = res_neg ? -acc[31:0] : acc[31:0];
        fix_hi = sign_a ? -acc[63:32] : acc[63:32];
      end
    end
  end

  // Datapath registers, HI/LO and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 2'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= 64'd0;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX) && !flush;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            mag_a  <= neg_a_in ? -rs_val : rs_val;
            mag_b  <= neg_b_in ? -rt_val : rt_val;
            acc    <= 64'd0;
            cnt    <= 5'd0;
          end else begin
            if (hi_we) hi <= wr_val;
            if (lo_we) lo <= wr_val;
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + 5'd1;
            if (op_q[1]) acc <= {div_rem, acc[30:0], div_qbit};
            else         acc <= {mul_sum, acc[31:1]};
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: arithmetic reference model compared
// every cycle, plus literal expectations for the directed vectors.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0, wr_val = 32'd0;
  logic        hi_we = 1'b0, lo_we = 1'b0, flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;
  int          m_left = 0;

  muldiv_hilo dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
    .wr_val(wr_val), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Result of an operation as {hi, lo}, straight from integer arithmetic.
  function automatic logic [63:0] model_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    int     q, r;
    logic [63:0] res;
    res = 64'd0;
    case (o)
      2'd0: begin
        p   = longint'($signed(a)) * longint'($signed(b));
        res = p;
      end
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Model: 33-cycle countdown from accept to result, flush aborts, direct writes in idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) m_busy = 1'b0;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_hi = m_res[63:32]; m_lo = m_res[31:0];
            m_done = 1'b1; m_busy = 1'b0;
          end
        end
      end else if (start) begin
        m_res  = model_res(op, rs_val, rt_val);
        m_busy = 1'b1;
        m_left = 33;
      end else begin
        if (hi_we) m_hi = wr_val;
        if (lo_we) m_lo = wr_val;
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b hi=%h lo=%h want busy=%b done=%b hi=%h lo=%h",
               $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Launch from a negedge, land on the negedge right after the result edge.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic with_lo_we);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    lo_we = with_lo_we; wr_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    repeat (33) @(negedge clk);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_minsq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_neg2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

    @(negedge clk);
    hi_we = 1'b1; wr_val = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
    hi_we = 1'b1; lo_we = 1'b1; wr_val = 32'h0000_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", hi, 32'h0000_5678);
    chk("mthilo_lo", lo, 32'h0000_5678);

    // Start and direct write during CALC must be ignored.
    start = 1'b1; op = 2'd1; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd3; rs_val = 32'd99; rt_val = 32'd3; hi_we = 1'b1; wr_val = 32'h0BAD_0BAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    repeat (27) @(negedge clk);
    chk("calc_ign_hi", hi, 32'd0);
    chk("calc_ign_lo", lo, 32'd42);

    // Flush mid-CALC: no update, no done.
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'd42);

    run_op("multu_3x5", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'd3; rs_val = 32'd1000; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_divu", 2'd3, 32'd1000, 32'd9, 32'd1, 32'd111, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
